// File: rtl/instr_fetch_unit_pkg.sv
// fetch_defs: state encoding and timeout counter sizing shared by the fetch unit
package fetch_defs;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_HOLD,
        FETCH_REDIR,
        FETCH_FAULT
    } fetch_state_t;
    function automatic int timeout_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction
endpackage

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter: counts enabled cycles since clear, flags when the count reaches limit
module fetch_timeout_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);
    logic [WIDTH-1:0] count;
    always_ff @(posedge clk) begin
        if (!resetN || clear) count <= '0;
        else if (enable) count <= count + 1'b1;
    end
    assign expired = (count == limit);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches the instruction at the current PC and hands it to decode, advancing or redirecting the PC
module instr_fetch_unit
    import fetch_defs::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [ADDR_WIDTH-1:0] addressIn,
    output logic                  pcSelect,
    output logic                  memReq,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic                  memAck,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic [DATA_WIDTH-1:0] instrOut,
    output logic [ADDR_WIDTH-1:0] instrAddr,
    output logic                  instrValid,
    input  logic                  instrReady,
    input  logic                  flush,
    output logic                  fetchFault
);
    localparam int TW = timeout_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
    fetch_state_t state, state_n;
    logic pc_select_n, instr_valid_n, fetch_fault_n, capture, expired, timeout_hit;
    fetch_timeout_counter #(.WIDTH(TW)) u_timeout (
        .clk     (clk),
        .resetN  (resetN),
        .clear   (state != FETCH_REQ),
        .enable  (state == FETCH_REQ && !memAck),
        .limit   (LIMIT),
        .expired (expired)
    );
    assign timeout_hit = expired && (TIMEOUT_CYCLES != 0);
    assign memReq  = (state == FETCH_REQ);
    assign memAddr = addressIn;
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= FETCH_IDLE;
            pcSelect   <= 1'b0;
            instrValid <= 1'b0;
            fetchFault <= 1'b0;
            instrOut   <= '0;
            instrAddr  <= '0;
        end else begin
            state      <= state_n;
            pcSelect   <= pc_select_n;
            instrValid <= instr_valid_n;
            fetchFault <= fetch_fault_n;
            if (capture) begin
                instrOut  <= memData;
                instrAddr <= addressIn;
            end
        end
    end
    always_comb begin
        state_n       = state;
        pc_select_n   = 1'b0;
        instr_valid_n = instrValid;
        fetch_fault_n = fetchFault;
        capture       = 1'b0;
        case (state)
            FETCH_IDLE: state_n = FETCH_REQ;
            FETCH_REQ: begin
                if (memAck) begin
                    pc_select_n   = 1'b1;
                    capture       = !flush;
                    instr_valid_n = !flush;
                    state_n       = flush ? FETCH_REDIR : FETCH_HOLD;
                end else if (timeout_hit) begin
                    fetch_fault_n = 1'b1;
                    state_n       = FETCH_FAULT;
                end
            end
            // A flush during the first HOLD cycle rides on the advance pulse already on pcSelect
            FETCH_HOLD: begin
                if (flush) begin
                    instr_valid_n = 1'b0;
                    pc_select_n   = !pcSelect;
                    state_n       = pcSelect ? FETCH_REQ : FETCH_REDIR;
                end else if (instrReady) begin
                    instr_valid_n = 1'b0;
                    state_n       = FETCH_REQ;
                end
            end
            FETCH_REDIR: state_n = FETCH_REQ;
            FETCH_FAULT: instr_valid_n = 1'b0;
            default: state_n = FETCH_IDLE;
        endcase
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks against a PC-register, memory and decode model
module tb_instr_fetch_unit;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    logic          clk        = 1'b0;
    logic          resetN     = 1'b0;
    logic [AW-1:0] addressIn  = '0;
    logic          memAck     = 1'b0;
    logic [DW-1:0] memData    = '0;
    logic          instrReady = 1'b0;
    logic          flush      = 1'b0;
    logic          pcSelect, memReq, instrValid, fetchFault;
    logic [AW-1:0] memAddr, instrAddr;
    logic [DW-1:0] instrOut;
    instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .addressIn  (addressIn),
        .pcSelect   (pcSelect),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memAck     (memAck),
        .memData    (memData),
        .instrOut   (instrOut),
        .instrAddr  (instrAddr),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .flush      (flush),
        .fetchFault (fetchFault)
    );
    always #5 clk = ~clk;
    int vectors = 0, miscompares = 0;
    int pulses, deliveries = 0, req_wait = 0, lat = 0, flush_age = 0, max_age = 0;
    logic [AW-1:0] pc = '0, target = '0, exp_fetch = '0, p_addr = '0;
    logic [DW-1:0] p_data = '0;
    logic pending = 1'b0, modeling = 1'b0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction
    // One clock: model decode/memory transactions from pre-edge values, then act as the PC register
    task automatic tick();
        logic ps, fl, req, ack, rdy;
        ps = pcSelect; fl = flush; req = memReq; ack = memAck; rdy = instrReady;
        if (modeling && resetN) begin
            if (pending && rdy && !fl) begin
                pending = 1'b0;
                deliveries++;
            end
            if (fl) pending = 1'b0;
            if (req && ack) begin
                check("fetch_addr", addressIn, exp_fetch);
                if (!fl) begin
                    pending   = 1'b1;
                    p_addr    = addressIn;
                    p_data    = mem_word(addressIn);
                    exp_fetch = addressIn + 32'd4;
                end
                req_wait = 0;
                lat = $urandom_range(0, 3);
            end else if (req) req_wait++;
        end
        @(posedge clk);
        @(negedge clk);
        if (resetN && ps) begin
            pc = fl ? target : pc + 32'd4;
            if (fl) begin
                flush = 1'b0;
                exp_fetch = target;
            end
        end
        addressIn = pc;
        if (modeling) begin
            check("valid", instrValid, pending);
            if (pending) begin
                check("instr_addr", instrAddr, p_addr);
                check("instr_out", instrOut, p_data);
            end
            check("pcsel_back_to_back", ps & pcSelect, 0);
            check("pcsel_with_req", pcSelect & memReq, 0);
        end
    endtask
    initial begin
        @(negedge clk);
        resetN = 0; memAck = 1; flush = 1; memData = 32'hDEAD_BEEF; instrReady = 1; target = 32'h40;
        tick(); tick();
        check("rst_memReq", memReq, 0);
        check("rst_pcSelect", pcSelect, 0);
        check("rst_instrValid", instrValid, 0);
        check("rst_fetchFault", fetchFault, 0);
        check("rst_instrOut", instrOut, 0);
        check("rst_instrAddr", instrAddr, 0);
        resetN = 1; memAck = 0; flush = 0; pc = '0; addressIn = '0;
        check("rel_memReq_c1", memReq, 0);
        tick();
        check("rel_memReq_c2", memReq, 1);
        memAck = 1; memData = 32'h8C01_0004; instrReady = 1;
        check("zw_memAddr", memAddr, 32'h0);
        tick();
        memAck = 0;
        check("zw_valid", instrValid, 1);
        check("zw_instrOut", instrOut, 32'h8C01_0004);
        check("zw_instrAddr", instrAddr, 32'h0);
        check("zw_pcSelect", pcSelect, 1);
        tick();
        check("zw_pcSelect_drop", pcSelect, 0);
        check("zw_valid_drop", instrValid, 0);
        check("zw_memReq", memReq, 1);
        check("zw_next_addr", memAddr, 32'h4);
        memAck = 1; memData = 32'h2402_0007; instrReady = 0;
        tick();
        memAck = 0; pulses = 0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", instrValid, 1);
            check("bp_instrOut", instrOut, 32'h2402_0007);
            check("bp_memReq", memReq, 0);
            pulses += int'(pcSelect);
            tick();
        end
        check("bp_pulses", pulses, 1);
        instrReady = 1;
        tick();
        check("bp_release_valid", instrValid, 0);
        check("bp_next_addr", memAddr, 32'h8);
        flush = 1; target = 32'h100; memAck = 0;
        tick(); tick();
        check("fr_valid_wait", instrValid, 0);
        memAck = 1; memData = 32'hFFFF_FFFF;
        tick();
        memAck = 0;
        check("fr_valid_redir", instrValid, 0);
        pulses = int'(pcSelect);
        tick();
        check("fr_valid_after", instrValid, 0);
        pulses += int'(pcSelect);
        check("fr_pulses", pulses, 1);
        check("fr_memReq", memReq, 1);
        check("fr_target", memAddr, 32'h100);
        repeat (3) tick();
        check("late_no_fault", fetchFault, 0);
        check("late_memReq", memReq, 1);
        memAck = 1; memData = 32'h1234_5678;
        tick();
        memAck = 0;
        check("late_valid", instrValid, 1);
        check("late_instrOut", instrOut, 32'h1234_5678);
        check("late_instrAddr", instrAddr, 32'h100);
        check("late_fault", fetchFault, 0);
        check("late_pcSelect", pcSelect, 1);
        flush = 1; target = 32'h200; instrReady = 0;
        tick();
        check("hf_pcSelect", pcSelect, 0);
        check("hf_valid", instrValid, 0);
        check("hf_memReq", memReq, 1);
        check("hf_target", memAddr, 32'h200);
        tick();
        check("hf_no_second_pcsel", pcSelect, 0);
        modeling = 1; pending = 0; exp_fetch = pc; req_wait = 0; lat = 0;
        for (int i = 0; i < 3000; i++) begin
            instrReady = $urandom_range(0, 3) != 0;
            if (!flush && $urandom_range(0, 11) == 0) begin
                flush = 1;
                target = $urandom & 32'hFFFF_FFFC;
            end
            if (memReq) begin
                memAck = (req_wait >= lat);
                memData = mem_word(addressIn);
            end else begin
                memAck = $urandom_range(0, 3) == 0;
                memData = $urandom;
            end
            flush_age = flush ? flush_age + 1 : 0;
            if (flush_age > max_age) max_age = flush_age;
            tick();
        end
        modeling = 0;
        check("rnd_flush_bound", max_age <= 12, 1);
        check("rnd_deliveries", deliveries >= 100, 1);
        check("rnd_no_fault", fetchFault, 0);
        resetN = 0; memAck = 1; flush = 0;
        tick(); tick();
        check("mid_rst_valid", instrValid, 0);
        check("mid_rst_memReq", memReq, 0);
        resetN = 1; memAck = 0;
        tick();
        repeat (3) tick();
        check("to_no_fault_yet", fetchFault, 0);
        check("to_memReq", memReq, 1);
        tick();
        check("to_fault", fetchFault, 1);
        check("to_memReq_off", memReq, 0);
        for (int i = 0; i < 5; i++) begin
            memAck = 1'($urandom); flush = 1'($urandom); instrReady = 1'($urandom);
            tick();
            check("fault_memReq", memReq, 0);
            check("fault_sticky", fetchFault, 1);
            check("fault_valid", instrValid, 0);
            check("fault_pcSelect", pcSelect, 0);
        end
        flush = 0; resetN = 0;
        tick();
        check("fault_cleared", fetchFault, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
